alarm_interval_timer: RTL and testbench
=======================================

# alarm_interval_timer

Programmable interval timer and time-parameter store serving car_alarm_fsm. The FSM selects one of four named intervals (arming delay, driver-door delay, passenger-door delay, siren-on time) and pulses a start request. This block loads the stored duration, counts it down in seconds derived from the system clock, and returns a one-cycle expiry pulse. A reprogram port lets the dashboard or service logic overwrite any interval at run time.

## Interface
- TICK_DIV, 4: clk cycles per "second" tick (≥2; sim value 4, silicon value = clk frequency)
- T_ARM_DELAY, 6: default arming-delay interval (seconds, 4-bit)
- T_DRIVER_DELAY, 8: default driver-door delay interval
- T_PASSENGER_DELAY, 15: default passenger-door delay interval
- T_ALARM_ON, 10: default siren-on interval

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_timer  in  1  load the selected interval and begin countdown (sampled each edge)
- interval_sel  in  2  interval for start_timer: 0 arm, 1 driver, 2 passenger, 3 alarm_on
- reprogram  in  1  write time_value into the parameter slot param_sel
- param_sel  in  2  slot written by reprogram (same encoding as interval_sel)
- time_value  in  4  new duration; 0 restores that slot's default
- expired  out  1  one-cycle pulse: countdown reached 0
- busy  out  1  countdown in progress (state RUN)
- second_tick  out  1  one-cycle pulse on every decrement edge
- remaining  out  4  current countdown value

## Operation
- Parameter store: four 4-bit registers; rst loads defaults. reprogram at an edge writes time_value (or the default if time_value==0) into slot param_sel.
- States: IDLE, RUN, EXPIRE.
- IDLE: start_timer -> load remaining = slot[interval_sel], clear divider; go RUN, or go EXPIRE if loaded value is 0.
- RUN: divider increments each cycle; when divider==TICK_DIV-1, divider wraps to 0, remaining decrements, second_tick pulses. If decrement makes remaining 0 -> EXPIRE.
- EXPIRE: expired=1 for exactly this one cycle; next edge -> IDLE, unless start_timer is high, which reloads as from IDLE.
- start_timer in RUN restarts: reload from the newly selected slot, clear divider, no expired pulse for the abandoned interval.
- start_timer and reprogram in the same cycle on the same slot: load uses the OLD slot value; the new value applies from the next start.
- reprogram during RUN never alters the active countdown.
- remaining holds its last value (0 after expiry) in IDLE until the next load.
- Decrement arithmetic is unsigned 4-bit; no wrap below 0 is possible because RUN exits at 0.

## Timing
- Reset values: expired=0, busy=0, second_tick=0, remaining=0, divider=0, state IDLE, slots = defaults.
- All outputs are registered; no combinational input-to-output path.
- start_timer sampled at edge k with loaded value V: busy=1 and remaining=V from edge k (V>0).
- Decrements occur at edges k+TICK_DIV, k+2·TICK_DIV, ...; expired rises at edge k+V·TICK_DIV and falls one edge later; busy falls at the same edge expired rises.
- V=0: expired rises at edge k; busy never rises.
- rst mid-countdown: next edge returns to IDLE with all outputs at reset values; no expired pulse; reprogrammed slots revert to defaults.
- rst has priority over start_timer and reprogram in the same cycle.

## Test plan
- Reset then start_timer, interval_sel=0, TICK_DIV=4 -> remaining=6, busy=1; expired pulses once exactly 24 cycles after the start edge; six second_tick pulses, remaining steps 6..0.
- Reprogram slot 1 with 3, then start slot 1 -> expired 12 cycles after start; reprogram slot 1 with 0, start slot 1 -> expired after 32 cycles (default 8 restored).
- Start slot 3, restart with slot 0 after 10 cycles -> no expiry at cycle 40; single expired 24 cycles after the restart.
- Same-cycle reprogram(slot 2, value 2) and start(slot 2) -> counts 15 (expired at 60 cycles); next start slot 2 -> expired at 8 cycles.
- rst asserted for one cycle while remaining=4 in RUN -> busy=0, remaining=0, no expired pulse, subsequent start slot 0 gives default 6.
- start_timer held high during EXPIRE -> single one-cycle expired pulse, immediate reload and busy=1 on the following edge.

Source files
------------

// File: rtl/alarm_interval_timer.sv
// alarm_interval_timer: programmable interval store plus seconds countdown with a one-cycle expiry pulse.
module alarm_interval_timer #(
    parameter int TICK_DIV = 4,
    parameter logic [3:0] T_ARM_DELAY = 4'd6,
    parameter logic [3:0] T_DRIVER_DELAY = 4'd8,
    parameter logic [3:0] T_PASSENGER_DELAY = 4'd15,
    parameter logic [3:0] T_ALARM_ON = 4'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_timer,
    input  logic [1:0] interval_sel,
    input  logic       reprogram,
    input  logic [1:0] param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       busy,
    output logic       second_tick,
    output logic [3:0] remaining
);
    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, RUN, EXPIRE} state_t;
    state_t state;
    logic [DW-1:0] div;
    logic [3:0] slots [4];
    logic [3:0] load_val;
    function automatic logic [3:0] def_val(input logic [1:0] s);
        return s == 2'd0 ? T_ARM_DELAY : s == 2'd1 ? T_DRIVER_DELAY :
               s == 2'd2 ? T_PASSENGER_DELAY : T_ALARM_ON;
    endfunction
    // Reads the pre-write slot, so a same-edge reprogram only affects later starts.
    assign load_val = slots[interval_sel];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            div <= '0;
            remaining <= '0;
            expired <= 1'b0;
            busy <= 1'b0;
            second_tick <= 1'b0;
            for (int i = 0; i < 4; i++) slots[i] <= def_val(2'(i));
        end else begin
            if (reprogram) slots[param_sel] <= time_value == 4'd0 ? def_val(param_sel) : time_value;
            expired <= 1'b0;
            second_tick <= 1'b0;
            if (start_timer) begin
                remaining <= load_val;
                div <= '0;
                state <= load_val == 4'd0 ? EXPIRE : RUN;
                expired <= load_val == 4'd0;
                busy <= load_val != 4'd0;
            end else begin
                case (state)
                    RUN: begin
                        if (div == DW'(TICK_DIV - 1)) begin
                            div <= '0;
                            remaining <= remaining - 4'd1;
                            second_tick <= 1'b1;
                            if (remaining == 4'd1) begin
                                state <= EXPIRE;
                                expired <= 1'b1;
                                busy <= 1'b0;
                            end
                        end else begin
                            div <= div + 1'b1;
                        end
                    end
                    EXPIRE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alarm_interval_timer.sv
// tb_alarm_interval_timer: directed checks of load, countdown, restart, reprogram and reset behaviour.
module tb_alarm_interval_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_timer = 1'b0;
    logic [1:0] interval_sel = '0;
    logic reprogram = 1'b0;
    logic [1:0] param_sel = '0;
    logic [3:0] time_value = '0;
    logic expired, busy, second_tick;
    logic [3:0] remaining;
    int compared = 0;
    int mismatched = 0;
    int first, pulses, ticks, rem4;

    alarm_interval_timer #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start_timer(start_timer), .interval_sel(interval_sel),
        .reprogram(reprogram), .param_sel(param_sel), .time_value(time_value),
        .expired(expired), .busy(busy), .second_tick(second_tick), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] sel);
        start_timer = 1'b1;
        interval_sel = sel;
        edge1();
        start_timer = 1'b0;
    endtask

    // Cycle index i counts edges after the start edge.
    task automatic observe(input int n, output int f, output int p, output int t, output int r4);
        f = -1; p = 0; t = 0; r4 = -1;
        for (int i = 1; i <= n; i++) begin
            edge1();
            if (expired) begin
                p++;
                if (f < 0) f = i;
            end
            if (second_tick) t++;
            if (i == 4) r4 = int'(remaining);
        end
    endtask

    initial begin
        edge1();
        edge1();
        rst = 1'b0;
        chk("reset_expired", 32'(expired), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_tick", 32'(second_tick), 0);
        chk("reset_remaining", 32'(remaining), 0);

        start(2'd0);
        chk("arm_load_rem", 32'(remaining), 6);
        chk("arm_load_busy", 32'(busy), 1);
        observe(30, first, pulses, ticks, rem4);
        chk("arm_expire_at", first, 24);
        chk("arm_pulses", pulses, 1);
        chk("arm_ticks", ticks, 6);
        chk("arm_rem_at4", rem4, 5);
        chk("arm_idle_rem", 32'(remaining), 0);
        chk("arm_idle_busy", 32'(busy), 0);

        reprogram = 1'b1; param_sel = 2'd1; time_value = 4'd3;
        edge1();
        reprogram = 1'b0;
        start(2'd1);
        chk("drv3_load", 32'(remaining), 3);
        observe(40, first, pulses, ticks, rem4);
        chk("drv3_expire_at", first, 12);
        reprogram = 1'b1; param_sel = 2'd1; time_value = 4'd0;
        edge1();
        reprogram = 1'b0;
        start(2'd1);
        observe(40, first, pulses, ticks, rem4);
        chk("drv_default_expire_at", first, 32);

        start(2'd3);
        chk("alarm_load", 32'(remaining), 10);
        observe(10, first, pulses, ticks, rem4);
        chk("alarm_pre_restart_pulses", pulses, 0);
        start(2'd0);
        chk("restart_load", 32'(remaining), 6);
        observe(45, first, pulses, ticks, rem4);
        chk("restart_expire_at", first, 24);
        chk("restart_pulses", pulses, 1);

        reprogram = 1'b1; param_sel = 2'd2; time_value = 4'd2;
        start(2'd2);
        reprogram = 1'b0;
        chk("same_cycle_load", 32'(remaining), 15);
        observe(70, first, pulses, ticks, rem4);
        chk("same_cycle_expire_at", first, 60);
        start(2'd2);
        observe(20, first, pulses, ticks, rem4);
        chk("new_pass_expire_at", first, 8);

        start(2'd0);
        observe(8, first, pulses, ticks, rem4);
        chk("pre_rst_rem", 32'(remaining), 4);
        rst = 1'b1; reprogram = 1'b1; param_sel = 2'd0; time_value = 4'd9;
        edge1();
        rst = 1'b0; reprogram = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rem", 32'(remaining), 0);
        chk("mid_rst_expired", 32'(expired), 0);
        observe(3, first, pulses, ticks, rem4);
        chk("post_rst_no_pulse", pulses, 0);
        start(2'd0);
        chk("post_rst_default", 32'(remaining), 6);
        observe(30, first, pulses, ticks, rem4);
        chk("post_rst_expire_at", first, 24);

        start(2'd1);
        observe(32, first, pulses, ticks, rem4);
        chk("hold_expire_at", first, 32);
        chk("hold_expired_now", 32'(expired), 1);
        chk("hold_busy_low", 32'(busy), 0);
        start_timer = 1'b1; interval_sel = 2'd0;
        edge1();
        chk("hold_expired_fell", 32'(expired), 0);
        chk("hold_reload_busy", 32'(busy), 1);
        chk("hold_reload_rem", 32'(remaining), 6);
        start_timer = 1'b0;
        observe(30, first, pulses, ticks, rem4);
        chk("hold_next_expire_at", first, 24);
        chk("hold_next_pulses", pulses, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
